// File: rtl/digit_fetch_scheduler.sv
// HH:MM:SS text-row renderer: freezes digits per frame, prefetches font rows one cell early.
// Optional BLINK_COLON_EN: colon cells blank while the frozen seconds-units digit is odd.
module digit_fetch_scheduler #(
  parameter int         X0    = 96,
  parameter int         Y0    = 16,
  parameter logic [3:0] COLOR = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_tick,
  input  logic [9:0]  pixelx,
  input  logic [9:0]  pixely,
  input  logic        video_on,
  input  logic [3:0]  horasD,
  input  logic [3:0]  horasU,
  input  logic [3:0]  minutosD,
  input  logic [3:0]  minutosU,
  input  logic [3:0]  segundosD,
  input  logic [3:0]  segundosU,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        pixel_on,
  output logic [3:0]  color_addr
);

  localparam logic [9:0] X0V   = 10'(X0);
  localparam logic [9:0] XLAST = 10'(X0 + 63);
  localparam logic [9:0] Y0V   = 10'(Y0);
  localparam logic [9:0] YLAST = 10'(Y0 + 15);
  localparam logic [3:0] Y0LO  = 4'(Y0);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_CAP, S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [10:0] rom_addr_q, rom_addr_d;
  logic [7:0]  pref_q, pref_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  hd_q, hu_q, md_q, mu_q, sd_q, su_q;
  logic [3:0]  hd_d, hu_d, md_d, mu_d, sd_d, su_d;
  logic        run_q, run_d;

  logic        band, x_in, in_window;
  logic [9:0]  fdx, load_x;
  logic        fetch_hit, load_hit, frame_tick;
  logic [2:0]  fetch_k;
  logic [3:0]  row;
  logic [6:0]  colon, code;

  function automatic logic [6:0] dig_code(input logic [3:0] d);
    return (d > 4'd9) ? 7'h3F : 7'h30 + {3'b000, d};
  endfunction

  // Raster decode: band/window flags and fetch/load pixel matches
  always_comb begin
    band       = (pixely >= Y0V) && (pixely <= YLAST);
    x_in       = (pixelx >= X0V) && (pixelx <= XLAST);
    in_window  = band && x_in;
    fdx        = pixelx + 10'd2 - X0V;
    fetch_k    = fdx[5:3];
    fetch_hit  = band && (fdx[9:6] == 4'd0) && (fdx[2:0] == 3'd0);
    load_x     = X0V - 10'd1 + {4'd0, k_q, 3'd0};
    load_hit   = (state_q == S_HOLD) && (pixelx == load_x);
    frame_tick = pixel_tick && (pixelx == 10'd0) && (pixely == 10'd0);
    row        = pixely[3:0] - Y0LO;
  end

  // Char code for the cell about to be fetched, from frozen digits
  always_comb begin
`ifdef BLINK_COLON_EN
    colon = su_q[0] ? 7'h20 : 7'h3A;
`else
    colon = 7'h3A;
`endif
    code = colon;
    case (fetch_k)
      3'd0:    code = dig_code(hd_q);
      3'd1:    code = dig_code(hu_q);
      3'd3:    code = dig_code(md_q);
      3'd4:    code = dig_code(mu_q);
      3'd6:    code = dig_code(sd_q);
      3'd7:    code = dig_code(su_q);
      default: code = colon;
    endcase
  end

  // Next-state: snapshot, fetch sequencer and pixel shifter
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    rom_addr_d = rom_addr_q;
    pref_d     = pref_q;
    shift_d    = shift_q;
    run_d      = 1'b1;
    {hd_d, hu_d, md_d, mu_d, sd_d, su_d} =
      {hd_q, hu_q, md_q, mu_q, sd_q, su_q};
    if (frame_tick)
      {hd_d, hu_d, md_d, mu_d, sd_d, su_d} =
        {horasD, horasU, minutosD, minutosU, segundosD, segundosU};
    case (state_q)
      S_IDLE: if (pixel_tick && fetch_hit) begin
        state_d    = S_REQ;
        k_d        = fetch_k;
        rom_addr_d = {code, row};
      end
      S_REQ:  state_d = S_CAP;
      S_CAP: begin
        pref_d  = rom_data;
        state_d = S_HOLD;
      end
      S_HOLD: if (pixel_tick && (!band || load_hit))
        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (pixel_tick) begin
      if (!band)                 shift_d = 8'd0;
      else if (load_hit)         shift_d = pref_q;
      else if (pixelx == XLAST)  shift_d = 8'd0;
      else if (x_in)             shift_d = {shift_q[6:0], 1'b0};
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 3'd0;
      rom_addr_q <= 11'd0;
      pref_q     <= 8'd0;
      shift_q    <= 8'd0;
      run_q      <= 1'b0;
      {hd_q, hu_q, md_q, mu_q, sd_q, su_q} <= 24'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      rom_addr_q <= rom_addr_d;
      pref_q     <= pref_d;
      shift_q    <= shift_d;
      run_q      <= run_d;
      {hd_q, hu_q, md_q, mu_q, sd_q, su_q} <=
        {hd_d, hu_d, md_d, mu_d, sd_d, su_d};
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pixel_on   = shift_q[7] & in_window & video_on;
  assign color_addr = (run_q && in_window) ? COLOR : 4'd0;

endmodule

// File: tb/tb_digit_fetch_scheduler.sv
// Bench for digit_fetch_scheduler: synchronous ROM model plus
// a queue of expected ROM requests checked as the DUT issues them.
module tb_digit_fetch_scheduler;

  localparam int X0 = 96;
  localparam int Y0 = 16;
  localparam logic [3:0] COLOR = 4'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_tick;
  logic [9:0]  pixelx, pixely;
  logic        video_on;
  logic [3:0]  hd, hu, md, mu, sd, su;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pixel_on;
  logic [3:0]  color_addr;

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0]  m [6];
  logic [10:0] sb_q [$];
  logic [10:0] last_addr;

  digit_fetch_scheduler #(.X0(X0), .Y0(Y0), .COLOR(COLOR)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick),
    .pixelx(pixelx), .pixely(pixely), .video_on(video_on),
    .horasD(hd), .horasU(hu), .minutosD(md), .minutosU(mu),
    .segundosD(sd), .segundosU(su),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_on(pixel_on), .color_addr(color_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [10:0] a);
    if (a[10:4] == 7'h31) return 8'hA5;
    return a[7:0] ^ {a[10:4], 1'b1};
  endfunction

  always @(posedge clk) rom_data <= rom_byte(rom_addr);

  function automatic logic [6:0] dc(input logic [3:0] d);
    return (d <= 4'd9) ? (7'h30 | {3'b000, d}) : 7'h3F;
  endfunction

  function automatic logic [6:0] exp_code(input int k);
    logic [6:0] col;
`ifdef BLINK_COLON_EN
    col = m[5][0] ? 7'h20 : 7'h3A;
`else
    col = 7'h3A;
`endif
    case (k)
      0: return dc(m[0]);
      1: return dc(m[1]);
      3: return dc(m[2]);
      4: return dc(m[3]);
      6: return dc(m[4]);
      7: return dc(m[5]);
      default: return col;
    endcase
  endfunction

  task automatic run_line(input int y, input bit vid,
                          input int leave_x, input int xmax);
    int yy, rel, frel;
    bit band, win, fetch, exp_on;
    logic [3:0]  r;
    logic [7:0]  b;
    logic [10:0] ea;
    logic [3:0]  ec;
    for (int x = 0; x < xmax; x++) begin
      yy    = (x >= leave_x) ? Y0 + 16 : y;
      band  = (yy >= Y0) && (yy <= Y0 + 15);
      win   = band && (x >= X0) && (x <= X0 + 63);
      rel   = x - X0;
      frel  = x + 2 - X0;
      fetch = band && frel >= 0 && frel < 64 && (frel % 8 == 0);
      r     = 4'(yy - Y0);
      @(negedge clk);
      pixelx = 10'(x); pixely = 10'(yy);
      video_on = vid; pixel_tick = 1'b1;
      #1;
      exp_on = 1'b0;
      if (win && vid) begin
        b = rom_byte({exp_code(rel / 8), r});
        exp_on = b[7 - (rel % 8)];
      end
      ec = win ? COLOR : 4'd0;
      n_vec++;
      if (pixel_on !== exp_on) begin
        n_bad++;
        $display("FAIL pixel_on x=%0d y=%0d got %b want %b",
                 x, yy, pixel_on, exp_on);
      end
      n_vec++;
      if (color_addr !== ec) begin
        n_bad++;
        $display("FAIL color_addr x=%0d y=%0d got %h want %h",
                 x, yy, color_addr, ec);
      end
      if (fetch) sb_q.push_back({exp_code(frel / 8), r});
      @(posedge clk); #1;
      pixel_tick = 1'b0;
      if (fetch) begin
        ea = sb_q.pop_front();
        last_addr = ea;
      end else begin
        ea = last_addr;
      end
      n_vec++;
      if (rom_addr !== ea) begin
        n_bad++;
        $display("FAIL rom_addr x=%0d y=%0d got %h want %h",
                 x, yy, rom_addr, ea);
      end
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    pixelx = 10'd0; pixely = 10'd0; pixel_tick = 1'b1;
    @(posedge clk); #1;
    pixel_tick = 1'b0;
    m[0] = hd; m[1] = hu; m[2] = md;
    m[3] = mu; m[4] = sd; m[5] = su;
    repeat (2) @(posedge clk);
  endtask

  task automatic set_time(input logic [23:0] t);
    {hd, hu, md, mu, sd, su} = t;
  endtask

  task automatic check_reset_outs(input string tag);
    n_vec++;
    if (pixel_on !== 1'b0) begin
      n_bad++;
      $display("FAIL %s pixel_on got %b want 0", tag, pixel_on);
    end
    n_vec++;
    if (color_addr !== 4'd0) begin
      n_bad++;
      $display("FAIL %s color_addr got %h want 0", tag, color_addr);
    end
    n_vec++;
    if (rom_addr !== 11'd0) begin
      n_bad++;
      $display("FAIL %s rom_addr got %h want 000", tag, rom_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pixel_tick = 1'b0; video_on = 1'b1;
    pixelx = 10'(X0 + 10); pixely = 10'(Y0 + 3);
    set_time(24'h000000);
    for (int i = 0; i < 6; i++) m[i] = 4'd0;
    last_addr = 11'd0;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("por");
    @(negedge clk) rst_n = 1'b1;
    set_time(24'h123456);
    frame_start();
    run_line(Y0 + 3, 1'b1, 9999, X0 + 11);
    @(negedge clk);
    pixelx = 10'(X0 + 10);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midline");
    for (int i = 0; i < 6; i++) m[i] = 4'd0;
    last_addr = 11'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_line(Y0 + 4, 1'b1, 9999, 200);
  endtask

  task automatic test_digits();
    set_time(24'h123456);
    frame_start();
    run_line(Y0 + 5, 1'b1, 9999, 200);
  endtask

  task automatic test_no_tear();
    set_time(24'h235959);
    run_line(Y0 + 6, 1'b1, 9999, 200);
    frame_start();
    run_line(Y0 + 6, 1'b1, 9999, 200);
  endtask

  task automatic test_bad_digit_video_off();
    set_time(24'hC35959);
    frame_start();
    run_line(Y0 + 7, 1'b0, 9999, 200);
    run_line(Y0 + 7, 1'b1, 9999, 200);
  endtask

  task automatic test_band_edges();
    run_line(Y0 - 1, 1'b1, 9999, 200);
    run_line(Y0, 1'b1, 9999, 200);
    run_line(Y0 + 15, 1'b1, 9999, 200);
    run_line(Y0 + 16, 1'b1, 9999, 200);
  endtask

  task automatic test_band_exit();
    run_line(Y0 + 8, 1'b1, X0 + 7, 200);
    run_line(Y0 + 9, 1'b1, 9999, 200);
  endtask

  task automatic test_colon();
    set_time(24'h104107);
    frame_start();
    run_line(Y0 + 2, 1'b1, 9999, 200);
    set_time(24'h104108);
    frame_start();
    run_line(Y0 + 2, 1'b1, 9999, 200);
  endtask

  initial begin
    test_reset();
    test_digits();
    test_no_tear();
    test_bad_digit_video_off();
    test_band_edges();
    test_band_exit();
    test_colon();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
